div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit signed/unsigned divider serving the multi-cycle controller's DIV/DIVU path.
- Accepts a one-cycle `div_start` or `divu_start` pulse and raises `busy`. The controller stalls its final state while `busy` is high.
- On completion, presents quotient (to LO) and remainder (to HI).
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- div_start  in  1  start a signed divide; sampled only when idle
- divu_start  in  1  start an unsigned divide; sampled only when idle
- dividend  in  WIDTH  Rs value, sampled in the start cycle
- divisor  in  WIDTH  Rt value, sampled in the start cycle
- busy  out  1  high from the edge after start until the result is ready
- done  out  1  one-cycle pulse in the first cycle results are valid
- q  out  WIDTH  quotient, destined for LO
- r  out  WIDTH  remainder, destined for HI
- div_zero  out  1  last operation had divisor == 0

Behaviour:

Reset:
- Async `rst` forces state IDLE; busy=0, done=0, q=0, r=0, div_zero=0, counter=0.
- Asserting rst mid-operation aborts the operation; no partial result is ever exposed.

States:
- IDLE: busy=0.
  - If div_start|divu_start at a clock edge, latch the operands and the mode (signed if div_start=1; div_start wins if both are high).
  - Compute the latched magnitudes: |dividend| and |divisor| in signed mode, raw values in unsigned mode.
  - Record sign_q = dividend[31]^divisor[31] and sign_r = dividend[31] (signed mode only; both 0 in unsigned mode).
  - Clear the partial remainder; counter=0; go to CALC.
- CALC: one restoring step per cycle.
  - Form {rem, quo} shifted left by 1.
  - Trial = rem - mag_divisor, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem = trial, quo[0] = 1. Otherwise quo[0] = 0.
  - counter++. After WIDTH steps (counter == WIDTH-1 on entry), go to FIX.
- FIX: one cycle.
  - q = sign_q ? -quo : quo; r = sign_r ? -rem : rem.
  - Register q, r and div_zero; pulse done=1; go to IDLE.
- Transitions not listed above do not exist.

Timing:
- Start at edge E makes busy=1 after E.
- busy stays high for exactly WIDTH+1 = 33 cycles.
- busy falls and done rises at the same edge; q/r are valid from that edge.
- q, r and div_zero hold their values until the next completed operation or reset.
- done is high for exactly one cycle.

Arithmetic:
- Truncation toward zero (MIPS semantics).
- Remainder takes the sign of the dividend.
- Magnitudes are treated as WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
- Signed overflow 0x80000000 / 0xFFFFFFFF produces q=0x80000000, r=0 with no flag.

Divide by zero:
- The normal 33-cycle latency is kept.
- q = all ones, r = original dividend (unsigned bits, no sign fix), div_zero=1.
- div_zero is cleared by the next non-zero-divisor completion.

Start while busy:
- Ignored; operands and mode are unchanged.
- A start pulse coinciding with the FIX cycle is also ignored.
- A start in the IDLE cycle immediately after done is accepted.

Operand stability:
- dividend and divisor may change after the start cycle without effect.

Test Plan:
- divu_start, dividend=100, divisor=7 -> busy high 33 cycles, then done pulse, q=14, r=2, div_zero=0.
- div_start, dividend=0xFFFFFF9C (-100), divisor=7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2); repeat with divisor=-7 -> q=14, r=0xFFFFFFFE.
- div_start, 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. divu_start with the same operands -> q=0, r=0x80000000.
- div_start, dividend=0x12345678, divisor=0 -> after 33 cycles q=0xFFFFFFFF, r=0x12345678, div_zero=1. Next op 9/3 -> q=3, r=0, div_zero=0.
- Start 50/5. At busy cycle 10, pulse divu_start with 1/1 and change the dividend input -> result remains q=10, r=0 and completes at cycle 33. A back-to-back start one cycle after done is accepted.
- Start 1000/3. Assert rst asynchronously mid-CALC, between edges -> busy, done, q, r drop to 0 immediately. After release, 1000/3 gives q=333, r=1.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider (signed/unsigned) for the DIV/DIVU path.
// One quotient bit per clock, plus one cycle for sign fix-up; quotient to LO, remainder to HI.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             divu_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, mag_dv, raw_dd;
  logic             sign_q, sign_r, dv_zero;

  logic             sgn;
  logic [WIDTH-1:0] mag_dd_in, mag_dv_in;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  // div_start wins when both pulses arrive together
  assign sgn       = div_start;
  assign mag_dd_in = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
  assign mag_dv_in = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Restoring step: trial sign bit says whether the subtraction fit
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, mag_dv};

  assign q_fix = sign_q ? -quo : quo;
  assign r_fix = sign_r ? -rem : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      mag_dv   <= '0;
      raw_dd   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dv_zero  <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start || divu_start) begin
            quo     <= mag_dd_in;
            mag_dv  <= mag_dv_in;
            raw_dd  <= dividend;
            sign_q  <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r  <= sgn & dividend[WIDTH-1];
            dv_zero <= (divisor == '0);
            rem     <= '0;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          // Divide by zero: all-ones quotient, untouched dividend as remainder
          if (dv_zero) begin
            q <= '1;
            r <= raw_dd;
          end else begin
            q <= q_fix;
            r <= r_fix;
          end
          div_zero <= dv_zero;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, multi-cycle corner sequences,
// and random operands checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start, divu_start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] q, r;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .div_start(div_start), .divu_start(divu_start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a, b, eq, er;
    bit          ez;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder follows the dividend
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mq, output logic [31:0] mr, output bit mz);
    if (b == 32'd0) begin
      mq = 32'hFFFFFFFF; mr = a; mz = 1'b1;
    end else begin
      mz = 1'b0;
      if (sgn) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          mq = 32'h80000000; mr = 32'd0;
        end else begin
          mq = $signed(a) / $signed(b);
          mr = $signed(a) % $signed(b);
        end
      end else begin
        mq = a / b;
        mr = a % b;
      end
    end
  endfunction

  // Called on a negedge; drives the start, counts busy cycles, checks results.
  // poke > 0 injects a divu_start 1/1 at that busy cycle, which must be ignored.
  task automatic run_op(input string nm, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input bit ez, input int poke);
    int n;
    div_start = sgn; divu_start = !sgn; dividend = a; divisor = b;
    @(negedge clk);
    div_start = 1'b0; divu_start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (n == poke) begin
        divu_start = 1'b1; dividend = 32'd1; divisor = 32'd1;
      end
      @(negedge clk);
      divu_start = 1'b0;
    end
    check({nm, ".latency"}, n, 32'd33);
    check({nm, ".done"}, {31'd0, done}, 32'd1);
    check({nm, ".q"}, q, eq);
    check({nm, ".r"}, r, er);
    check({nm, ".dz"}, {31'd0, div_zero}, {31'd0, ez});
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] mq, mr, a, b;
    bit          mz, sgn;

    vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
    vecs[1]  = '{1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   0};
    vecs[2]  = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   0};
    vecs[3]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
    vecs[4]  = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0};
    vecs[5]  = '{1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1};
    vecs[6]  = '{1, 32'd9,          32'd3,          32'd3,          32'd0,          0};
    vecs[7]  = '{0, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1};
    vecs[8]  = '{1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1};
    vecs[9]  = '{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          0};
    vecs[10] = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0};

    rst = 1'b1; div_start = 1'b0; divu_start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.q", q, 32'd0);
    check("rst.r", r, 32'd0);
    check("rst.dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table runs back-to-back: each start lands in the done cycle
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].eq, vecs[i].er, vecs[i].ez, 0);

    // Start pulse mid-calculation is ignored
    @(negedge clk);
    run_op("poke10", 1, 32'd50, 32'd5, 32'd10, 32'd0, 0, 10);
    // Start pulse in the fix-up cycle is ignored
    run_op("poke33", 0, 32'd77, 32'd10, 32'd7, 32'd7, 0, 33);
    @(negedge clk);
    check("poke33.idle", {31'd0, busy}, 32'd0);
    check("poke33.done_one", {31'd0, done}, 32'd0);
    check("poke33.hold_q", q, 32'd7);

    // Asynchronous reset mid-calculation
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.q", q, 32'd0);
    check("arst.r", r, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst.stay_idle", {31'd0, busy}, 32'd0);
    run_op("after_rst", 1, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 0);

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(sgn, a, b, mq, mr, mz);
      run_op($sformatf("rnd%0d", i), sgn, a, b, mq, mr, mz, 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
